// File: rtl/div_issue.sv
`default_nettype none
// ============================================================================
// Module   : div_issue
// Brief    : Issue/writeback sequencer for a multi-cycle 64-bit divider core.
//            Define DIV_FASTPATH_EN to resolve divide-by-zero and signed
//            overflow in one cycle without the core.
// Revision : 1.0 - initial release
// ============================================================================
module div_issue (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  op,
    input  logic        word,
    input  logic [63:0] src1,
    input  logic [63:0] src2,
    input  logic [4:0]  tag,
    input  logic        flush,
    output logic        div_valid,
    output logic        div_sign,
    output logic [63:0] div_x,
    output logic [63:0] div_y,
    input  logic [63:0] div_result,
    input  logic [63:0] div_rem,
    input  logic        div_finish,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_data,
    output logic [4:0]  out_tag
);

    localparam logic [2:0] S_IDLE  = 3'd0;
`ifdef DIV_FASTPATH_EN
    localparam logic [2:0] S_FAST  = 3'd1;
`endif
    localparam logic [2:0] S_ISSUE = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_HOLD  = 3'd4;
    localparam logic [2:0] S_DRAIN = 3'd5;

    logic [2:0]  r_state;
    logic        r_is_rem;
    logic        r_word;
    logic        r_sign;
    logic [4:0]  r_tag;
    logic [63:0] r_x;
    logic [63:0] r_y;
    logic [63:0] r_data;

    logic        w_signed;
    logic        w_accept;
    logic [63:0] w_x;
    logic [63:0] w_y;
    logic [63:0] w_core_res;

    // Word results are always sign-extended from bit 31, even for unsigned ops.
    function automatic logic [63:0] wb_fmt(input logic [63:0] val, input logic is_word);
        return is_word ? {{32{val[31]}}, val[31:0]} : val;
    endfunction

    assign w_signed = ~op[0];
    assign w_accept = in_valid && in_ready && !flush;

    always_comb begin
        w_x = src1;
        w_y = src2;
        if (word) begin
            w_x = w_signed ? {{32{src1[31]}}, src1[31:0]} : {32'd0, src1[31:0]};
            w_y = w_signed ? {{32{src2[31]}}, src2[31:0]} : {32'd0, src2[31:0]};
        end
    end

    assign w_core_res = wb_fmt(r_is_rem ? div_rem : div_result, r_word);

`ifdef DIV_FASTPATH_EN
    logic        w_fast;
    logic [63:0] w_min;
    logic [63:0] w_fast_res;

    assign w_min  = word ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000;
    assign w_fast = (w_y == 64'd0) || (w_signed && (w_x == w_min) && (w_y == {64{1'b1}}));
    // Zero divisor: q = all ones, r = dividend. Overflow: q = dividend, r = 0.
    assign w_fast_res = wb_fmt((r_y == 64'd0) ? (r_is_rem ? r_x : {64{1'b1}})
                                              : (r_is_rem ? 64'd0 : r_x), r_word);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_is_rem <= 1'b0;
            r_word   <= 1'b0;
            r_sign   <= 1'b0;
            r_tag    <= 5'd0;
            r_x      <= 64'd0;
            r_y      <= 64'd0;
            r_data   <= 64'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_is_rem <= op[1];
                        r_word   <= word;
                        r_sign   <= w_signed;
                        r_tag    <= tag;
                        r_x      <= w_x;
                        r_y      <= w_y;
`ifdef DIV_FASTPATH_EN
                        r_state  <= w_fast ? S_FAST : S_ISSUE;
`else
                        r_state  <= S_ISSUE;
`endif
                    end
                end
`ifdef DIV_FASTPATH_EN
                S_FAST: begin
                    if (flush) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_data  <= w_fast_res;
                        r_state <= S_HOLD;
                    end
                end
`endif
                S_ISSUE: r_state <= flush ? S_DRAIN : S_WAIT;
                S_WAIT: begin
                    // A finish coinciding with flush completes the core, so nothing is left to drain.
                    if (div_finish) begin
                        if (flush) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_data  <= w_core_res;
                            r_state <= S_HOLD;
                        end
                    end else if (flush) begin
                        r_state <= S_DRAIN;
                    end
                end
                S_HOLD: begin
                    if (flush || out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                S_DRAIN: begin
                    if (div_finish) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = !rst && (r_state == S_IDLE);
    assign div_valid = (r_state == S_ISSUE);
    assign div_sign  = r_sign;
    assign div_x     = r_x;
    assign div_y     = r_y;
    assign out_valid = (r_state == S_HOLD);
    assign out_data  = r_data;
    assign out_tag   = r_tag;

endmodule
`default_nettype wire

// File: tb/tb_div_issue.sv
`default_nettype none
// Testbench for div_issue: directed vectors checked through a scoreboard queue,
// with a behavioural multi-cycle divider core answering div_valid.
module tb_div_issue;

    localparam int CORE_LAT = 6;
    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  op = 2'b00;
    logic        word = 1'b0;
    logic [63:0] src1 = '0;
    logic [63:0] src2 = '0;
    logic [4:0]  tag = '0;
    logic        flush = 1'b0;
    logic        div_valid;
    logic        div_sign;
    logic [63:0] div_x;
    logic [63:0] div_y;
    logic [63:0] div_result;
    logic [63:0] div_rem;
    logic        div_finish;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [63:0] out_data;
    logic [4:0]  out_tag;

    int n_vec = 0;
    int n_bad = 0;
    logic [63:0] exp_q[$];
    logic [4:0]  tag_q[$];
    logic [4:0]  stall_tag = 5'd31;

    logic core_fin = 1'b0;
    logic spur_a = 1'b0;
    logic spur_b = 1'b0;
    int   core_cnt = 0;
    int   fin_count = 0;

    div_issue dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .word(word), .src1(src1), .src2(src2), .tag(tag), .flush(flush),
        .div_valid(div_valid), .div_sign(div_sign), .div_x(div_x), .div_y(div_y),
        .div_result(div_result), .div_rem(div_rem), .div_finish(div_finish),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag)
    );

    always #5 clk = ~clk;

    // Core reads its operands and sign live, so any drift while busy corrupts the answer.
    function automatic logic [63:0] core_div(input logic [63:0] x, input logic [63:0] y,
                                             input logic s, input logic want_rem);
        logic [63:0] q;
        logic [63:0] r;
        if (y == 64'd0) begin
            q = '1;
            r = x;
        end else if (s && x == 64'h8000_0000_0000_0000 && y == '1) begin
            q = x;
            r = '0;
        end else if (s) begin
            q = $signed(x) / $signed(y);
            r = $signed(x) % $signed(y);
        end else begin
            q = x / y;
            r = x % y;
        end
        return want_rem ? r : q;
    endfunction

    always @(posedge clk) begin
        core_fin <= 1'b0;
        if (div_valid) begin
            core_cnt <= CORE_LAT;
        end else if (core_cnt > 0) begin
            core_cnt <= core_cnt - 1;
            if (core_cnt == 1) begin
                core_fin  <= 1'b1;
                fin_count <= fin_count + 1;
            end
        end
    end

    assign div_finish = core_fin | spur_a | spur_b;
    assign div_result = (spur_a | spur_b) ? 64'hDEAD_BEEF_DEAD_BEEF : core_div(div_x, div_y, div_sign, 1'b0);
    assign div_rem    = (spur_a | spur_b) ? 64'hBAD0_BAD0_BAD0_BAD0 : core_div(div_x, div_y, div_sign, 1'b1);

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", name, got, want);
        end
    endtask

    task automatic send(input logic [1:0] o, input logic w, input logic [63:0] a,
                        input logic [63:0] b, input logic [4:0] t,
                        input logic [63:0] want, input bit expect_out);
        bit acc;
        acc = 1'b0;
        op = o; word = w; src1 = a; src2 = b; tag = t; in_valid = 1'b1;
        for (int i = 0; i < 300 && !acc; i++) begin
            @(negedge clk);
            if (in_ready) begin
                acc = 1'b1;
                if (expect_out) begin
                    exp_q.push_back(want);
                    tag_q.push_back(t);
                end
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!acc) begin
            n_vec++;
            n_bad++;
            $display("FAIL accept_timeout: tag %0d never accepted", t);
        end
    endtask

    // Monitor: pops the scoreboard on each writeback and polices HOLD behaviour.
    initial begin
        int          stall_cnt;
        logic [63:0] pd;
        logic [4:0]  pt;
        logic [63:0] e;
        logic [4:0]  et;
        bit          hp;
        bit          pdv;
        stall_cnt = 0; hp = 1'b0; pdv = 1'b0; pd = '0; pt = '0;
        forever begin
            @(negedge clk);
            spur_a = 1'b0;
            if (div_valid) begin
                n_vec++;
                if (pdv) begin
                    n_bad++;
                    $display("FAIL div_valid_pulse: got 2+ cycles, want 1");
                end
            end
            pdv = div_valid;
            if (rst || !out_valid) begin
                out_ready = 1'b1;
                hp = 1'b0;
                stall_cnt = 0;
            end else begin
                if (hp) begin
                    n_vec++;
                    if (out_data !== pd || out_tag !== pt) begin
                        n_bad++;
                        $display("FAIL hold_stable: got %h/%0d, want %h/%0d", out_data, out_tag, pd, pt);
                    end
                end
                pd = out_data; pt = out_tag; hp = 1'b1;
                if (out_tag == stall_tag && stall_cnt < 5) begin
                    out_ready = 1'b0;
                    stall_cnt++;
                    if (stall_cnt == 3) spur_a = 1'b1;
                    n_vec++;
                    if (in_ready !== 1'b0) begin
                        n_bad++;
                        $display("FAIL hold_in_ready: got %b, want 0", in_ready);
                    end
                end else begin
                    out_ready = 1'b1;
                    hp = 1'b0;
                    n_vec++;
                    if (exp_q.size() == 0) begin
                        n_bad++;
                        $display("FAIL unexpected_out: got tag %0d data %h, want no output", out_tag, out_data);
                    end else begin
                        e  = exp_q.pop_front();
                        et = tag_q.pop_front();
                        if (out_data !== e || out_tag !== et) begin
                            n_bad++;
                            $display("FAIL out_data: got %h tag %0d, want %h tag %0d", out_data, out_tag, e, et);
                        end
                    end
                end
            end
        end
    end

    initial begin
        int fc;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready",  {63'd0, in_ready},  64'd0);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_div_valid", {63'd0, div_valid}, 64'd0);
        chk("rst_div_sign",  {63'd0, div_sign},  64'd0);
        chk("rst_out_data",  out_data, 64'd0);
        chk("rst_out_tag",   {59'd0, out_tag}, 64'd0);
        chk("rst_div_x",     div_x, 64'd0);
        chk("rst_div_y",     div_y, 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", {63'd0, in_ready}, 64'd1);
        @(posedge clk);
        #1;

        send(OP_DIV, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd1, 64'hFFFF_FFFF_FFFF_FFFD, 1'b1);
        send(OP_REM, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd2, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
        send(OP_DIVU, 1'b0, 64'd5, 64'd0, 5'd3, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
`ifdef DIV_FASTPATH_EN
        @(posedge clk);
        #1;
        chk("fast_latency", {63'd0, out_valid}, 64'd1);
`endif
        send(OP_REMU, 1'b0, 64'd5, 64'd0, 5'd4, 64'd5, 1'b1);
        send(OP_DIV, 1'b0, 64'h8000_0000_0000_0000, '1, 5'd5, 64'h8000_0000_0000_0000, 1'b1);
        send(OP_REM, 1'b0, 64'h8000_0000_0000_0000, '1, 5'd6, 64'd0, 1'b1);
        send(OP_DIV, 1'b1, 64'h1234_5678_8000_0000, 64'h0000_0000_FFFF_FFFF, 5'd7, 64'hFFFF_FFFF_8000_0000, 1'b1);
        stall_tag = 5'd8;
        send(OP_DIVU, 1'b1, 64'd100, 64'd7, 5'd8, 64'd14, 1'b1);
        send(OP_DIVU, 1'b0, '1, 64'd2, 5'd9, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1);
        send(OP_REM, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'd3, 5'd10, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
        send(OP_REMU, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd16, 5'd11, 64'd9, 1'b1);
        send(OP_DIVU, 1'b1, 64'h0000_0000_FFFF_FFFE, 64'd1, 5'd12, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1);

        // Flush while the core is busy: result dropped, input blocked until the core finishes.
        send(OP_DIV, 1'b0, 64'd1000, 64'd10, 5'd13, 64'd0, 1'b0);
        @(posedge clk);
        #1;
        flush = 1'b1;
        fc = fin_count;
        @(posedge clk);
        #1 flush = 1'b0;
        for (int i = 0; i < 20 && fin_count == fc; i++) begin
            @(negedge clk);
            chk("drain_in_ready", {63'd0, in_ready}, 64'd0);
        end
        if (fin_count == fc) chk("drain_core_finish", 64'd0, 64'd1);
        @(posedge clk);
        @(negedge clk);
        chk("drain_exit_in_ready", {63'd0, in_ready}, 64'd1);
        @(posedge clk);
        #1;
        send(OP_DIV, 1'b0, 64'd1000, 64'd10, 5'd14, 64'd100, 1'b1);

        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(posedge clk);
        #1;
        in_valid = 1'b1; flush = 1'b1;
        op = OP_DIV; word = 1'b0; src1 = 64'd20; src2 = 64'd5; tag = 5'd15;
        @(posedge clk);
        #1;
        in_valid = 1'b0; flush = 1'b0;
        chk("flush_idle_no_issue", {63'd0, div_valid}, 64'd0);
        chk("flush_idle_in_ready", {63'd0, in_ready}, 64'd1);

        spur_b = 1'b1;
        @(posedge clk);
        #1 spur_b = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("idle_spurious_finish", {63'd0, in_ready}, 64'd1);

        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(posedge clk);
        if (exp_q.size() != 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL drain_timeout: got %0d outputs pending, want 0", exp_q.size());
        end
        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/div_issue.md
DIV_ISSUE -- requirements
Module: div_issue

Interface
REQ-001 SHALL: clk  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL: rst  input  1  synchronous active-high reset.
REQ-003 SHALL: in_valid / in_ready  input / output  1 / 1  request handshake; accepted on a cycle where both are 1.
REQ-004 SHALL: op  input  2  00 DIV, 01 DIVU, 10 REM, 11 REMU; word  input  1  32-bit variant (DIVW etc.).
REQ-005 SHALL: src1, src2  input  64  dividend, divisor; tag  input  5  destination register, passed through.
REQ-006 SHALL: flush  input  1  discard in-flight and pending work.
REQ-007 SHALL: div_valid output 1; div_sign output 1; div_x, div_y output 64 -- drive the divider core.
REQ-008 SHALL: div_result, div_rem input 64; div_finish input 1 -- returned from the divider core.
REQ-009 SHALL: out_valid output 1; out_ready input 1; out_data output 64; out_tag output 5 -- writeback handshake.

Function
REQ-010 SHALL implement states IDLE, FAST, ISSUE, WAIT, HOLD, DRAIN; in_ready=1 only in IDLE.
REQ-011 SHALL on accept latch op, word, tag and prepared operands; word=1: src1/src2 low 32 bits sign-extended (signed ops) or zero-extended (DIVU/REMU) to 64.
REQ-012 SHALL set div_sign=1 for DIV/REM, 0 for DIVU/REMU; div_x, div_y, div_sign held constant from ISSUE entry until WAIT exit (core samples operand sign live).
REQ-013 SHALL on accept go FAST if fast-path condition (REQ-019) holds, else ISSUE.
REQ-014 SHALL assert div_valid for exactly the one ISSUE cycle, then go WAIT.
REQ-015 SHALL in WAIT, on div_finish=1, capture div_result (DIV/DIVU) or div_rem (REM/REMU) and go HOLD; out_valid rises the next cycle.
REQ-016 SHALL for word=1, set out_data = sign-extension of bit 31 of the selected 64-bit value.
REQ-017 SHALL in HOLD keep out_valid=1 with out_data/out_tag stable until out_ready=1, then return to IDLE; no bypass from HOLD to accept.
REQ-018 SHALL FAST produce result in one cycle: accept at edge N, out_valid=1 from edge N+1 (via HOLD).
REQ-019 SHALL fast-path conditions (operands after REQ-011): divisor zero -> quotient all ones, remainder = dividend; signed op with dividend = min value (64- or 32-bit per word) and divisor -1 -> quotient = dividend, remainder 0.
REQ-020 SHALL on flush=1: IDLE/FAST/HOLD -> IDLE, output dropped; ISSUE/WAIT -> DRAIN (core cannot be aborted); flush with in_valid in IDLE -> not accepted.
REQ-021 SHALL in DRAIN keep in_ready=0, discard core output, return to IDLE on div_finish.
REQ-022 SHALL treat div_finish outside WAIT/DRAIN as ignored.

Reset
REQ-023 SHALL on rst=1 enter IDLE; out_valid, div_valid, div_sign = 0; out_data, out_tag, div_x, div_y = 0; in_ready = 0 during rst, 1 after.
REQ-024 SHALL give rst priority over flush and all handshakes.

Configuration
REQ-025 SHALL compile FAST state and REQ-019 only when DIV_FASTPATH_EN is defined.
REQ-026 SHALL without DIV_FASTPATH_EN send every request through ISSUE/WAIT; divide-by-zero and overflow results are then whatever the core returns, unchecked.

Verification
REQ-027 SHALL: DIV src1=-7, src2=2 -> out_data=-3; REM same operands -> out_data=-1 (0xFFFF_FFFF_FFFF_FFFF).
REQ-028 SHALL: DIVU src2=0, src1=5 (macro on) -> out_valid one cycle after accept, out_data=0xFFFF_FFFF_FFFF_FFFF; REMU -> 5.
REQ-029 SHALL: DIV src1=0x8000_0000_0000_0000, src2=-1 (macro on) -> out_data=0x8000_0000_0000_0000; REM -> 0.
REQ-030 SHALL: DIVW src1=0x1234_5678_8000_0000, src2=0xFFFF_FFFF (macro on) -> out_data=0xFFFF_FFFF_8000_0000; DIVUW src1=100, src2=7 -> 14.
REQ-031 SHALL: out_ready held 0 for 5 cycles after out_valid -> out_data/out_tag stable, in_ready=0 throughout.
REQ-032 SHALL: flush in WAIT -> no out_valid for that request, in_ready=0 until div_finish, next request gets correct result.
